// File: rtl/tc_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers behind the bridge,
// one-shot or auto-reload operation, maskable level interrupt.
module tc_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t      state;
    state_t      state_next;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;

    logic        wr;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        ctrl_en;
    logic        ctrl_im;
    logic        auto_reload;
    logic        count_gt_one;

    logic        load_count;
    logic        dec_count;
    logic        zero_count;
    logic        set_flag;
    logic        int_clr_flag;
    logic        int_clr_en;

    // Only full-word writes reach the registers; COUNT and offset 3 have no write path.
    assign wr           = sel & (byteen == 4'b1111);
    assign wr_ctrl      = wr & (addr == ADDR_CTRL);
    assign wr_preset    = wr & (addr == ADDR_PRESET);

    assign ctrl_en      = ctrl[0];
    assign ctrl_im      = ctrl[3];
    assign auto_reload  = (ctrl[2:1] == 2'b01);
    assign count_gt_one = (count > 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ctrl_en) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = CNT;
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_next = IDLE;
                end else if (!count_gt_one) begin
                    state_next = INT;
                end
            end
            INT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        load_count   = 1'b0;
        dec_count    = 1'b0;
        zero_count   = 1'b0;
        set_flag     = 1'b0;
        int_clr_flag = 1'b0;
        int_clr_en   = 1'b0;
        case (state)
            LOAD: begin
                load_count = 1'b1;
            end
            CNT: begin
                if (ctrl_en) begin
                    dec_count  = count_gt_one;
                    zero_count = !count_gt_one;
                    set_flag   = !count_gt_one;
                end
            end
            INT: begin
                int_clr_flag = auto_reload;
                int_clr_en   = !auto_reload;
            end
            default: begin
            end
        endcase
    end

    // A bus write to CTRL wins over the one-shot EN clear in the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl <= 4'd0;
        end else if (wr_ctrl) begin
            ctrl <= wdata[3:0];
        end else if (int_clr_en) begin
            ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 32'd0;
        end else if (load_count) begin
            count <= preset;
        end else if (dec_count) begin
            count <= count - 32'd1;
        end else if (zero_count) begin
            count <= 32'd0;
        end
    end

    // Software acknowledges the interrupt by writing CTRL or PRESET.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag <= 1'b0;
        end else if (wr_ctrl || wr_preset) begin
            flag <= 1'b0;
        end else if (set_flag) begin
            flag <= 1'b1;
        end else if (int_clr_flag) begin
            flag <= 1'b0;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_CTRL:   rdata = {28'd0, ctrl};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            default:     rdata = 32'd0;
        endcase
    end

    assign irq = flag & ctrl_im;

endmodule

// File: doc/tc_timer.md
# tc_timer

Memory-mapped programmable timer sitting on the CPU data bus as a responder behind the system bridge, one instance per timer window (TC1 at 0x7F00, TC2 at 0x7F10). It accepts full-word register reads and writes, counts down from a preset value, and drives one `HWInt` interrupt line back into CP0. The CPU already raises AdEL/AdES for sub-word or COUNT-store accesses, but this block must still tolerate them safely.

## Interface
- No parameters; the base address is decoded by the bridge, and this block sees only the word offset.
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `sel` in 1: bridge chip-select; `m_data_addr` falls in this timer's 3-word window.
- `addr` in 2: word offset `m_data_addr[3:2]`. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `byteen` in 4: CPU `m_data_byteen` (already gated by `Req`).
- `wdata` in 32: CPU `m_data_wdata`.
- `rdata` out 32: read data, muxed by the bridge into `m_data_rdata`.
- `irq` out 1: interrupt request to one `HWInt` bit.

## Operation
- **Write enable.** `wr = sel & (byteen == 4'b1111)`.
  - Any other `byteen` with `sel` is ignored.
  - Writes to COUNT and to the reserved offset are ignored.
- **CTRL register.** Only bits [3:0] are stored; the upper bits read 0.
  - [0] EN: count enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload. Values 1x behave as 00.
  - [3] IM: interrupt mask (1 = irq allowed out).
- **PRESET and COUNT.** PRESET is a 32-bit read/write register. COUNT is 32-bit and read-only.
- **Reads.** Combinational, no side effects: `rdata = {28'b0, CTRL[3:0]}`, PRESET, COUNT, or 0 according to `addr`. `rdata` is valid whenever `sel` is high and is a don't-care otherwise.
- **Interrupt flag.** `irq = flag & CTRL[3]`. `flag` is internal.
- **State machine** (2-bit state: IDLE, LOAD, CNT, INT):
  - IDLE: if EN is 1, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if EN is 0, go to IDLE with COUNT frozen. Else if COUNT > 1, COUNT <= COUNT − 1. Else COUNT <= 0, flag <= 1, go to INT.
  - INT, MODE 00: EN <= 0, go to IDLE, flag stays set.
  - INT, MODE 01: flag <= 0, go to IDLE. EN is still 1, so the timer reloads.
- **Bus write side effects.**
  - A write to CTRL or PRESET clears `flag` in the same edge.
  - A bus write to CTRL overrides the INT-state EN clear in the same cycle; the bus value wins.
  - A PRESET write mid-count does not affect COUNT until the next LOAD.
- **PRESET = 0.** LOAD sets COUNT = 0, and CNT goes to INT on the next edge.
- **Counter arithmetic.** Unsigned 32-bit, never wraps below 0.

## Timing
- **Reset** (asynchronous, `rst` low): CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, flag = 0. So `irq = 0` and `rdata` = 0 for every offset.
- **Release.** Leaving reset is synchronous to the next `clk` edge. Asserting `rst` mid-count aborts immediately to the reset values.
- **Write latency.** A write is sampled on edge E0 and is visible in `rdata` after E0.
- **Countdown timeline** for an EN=1 write at E0 with PRESET = N ≥ 1:
  - E1: state LOAD.
  - E2: COUNT = N.
  - COUNT decrements each edge, reaching 1 after E(N+1).
  - E(N+2): COUNT = 0, state INT, flag = 1.
  - `irq` rises after E(N+2) if IM = 1.
- **One-shot** (MODE 00): `irq` stays high until software writes CTRL or PRESET. EN reads 0 after E(N+3).
- **Auto-reload** (MODE 01):
  - `irq` is a 1-cycle pulse; flag clears at E(N+3).
  - LOAD occurs at E(N+4) and COUNT = N at E(N+5).
  - Interrupt period is N+3 cycles.
- **IM toggling** masks or unmasks `irq` combinationally without touching `flag`.
- **EN cleared in CNT** (write at E0): the state machine reads the new EN on the next edge. COUNT still decrements at E0, goes to IDLE at E1, then stays frozen.

## Test plan
- Reset: drive `rst` low mid-count → `irq` = 0, and CTRL/PRESET/COUNT read 0 asynchronously.
- One-shot: PRESET = 3, CTRL = 0x9 → COUNT reads 3, 2, 1, 0, and `irq` rises after the 5th edge following the CTRL write. `irq` holds high and CTRL reads 0x8. A PRESET write of 5 then drops `irq`.
- Auto-reload: PRESET = 2, CTRL = 0xB → `irq` is a 1-cycle pulse every 5 cycles, for at least 3 periods, and CTRL stays 0xB.
- Masking: one-shot with IM = 0 → `irq` = 0 with COUNT = 0. Writing IM = 1 (CTRL = 0x8) clears flag, so `irq` stays 0.
- Pause and edge cases:
  - Clearing EN mid-count at COUNT = 7 freezes COUNT at 6.
  - PRESET = 0 with EN → `irq` 3 edges after the write.
- Illegal accesses: `byteen` = 4'b0011 to PRESET, a full write to COUNT, and a full write to offset 3 → no register changes, offset 3 reads 0.
